// File: rtl/audio_avg_pkg.sv
// Shared definitions for the audio magnitude averager.
//   - default widths for sample, window and published result
//   - derived widths for the magnitude and the accumulator
//   - output handshake FSM state encoding
package audio_avg_pkg;

  localparam int SAMPLE_WIDTH_DEF = 16;
  localparam int LOG2_WINDOW_DEF  = 8;
  localparam int OUT_WIDTH_DEF    = 8;

  localparam int MAG_WIDTH = SAMPLE_WIDTH_DEF - 1;
  localparam int ACC_WIDTH = SAMPLE_WIDTH_DEF - 1 + LOG2_WINDOW_DEF;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Accumulator width that holds a full window of maximum magnitudes without overflow.
  function automatic int acc_width(input int sample_w, input int log2_win);
    return sample_w - 1 + log2_win;
  endfunction

endpackage

// File: rtl/abs_saturate.sv
// Combinational saturated absolute value of a two's-complement input.
//   x_i   [WIDTH-1:0]  signed input
//   mag_o [WIDTH-2:0]  unsigned magnitude; the most negative input clamps to all-ones
module abs_saturate #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-2:0] mag_o
);

  logic is_min;

  assign is_min = (x_i == {1'b1, {(WIDTH-1){1'b0}}});

  // For negative inputs the low WIDTH-1 bits of the two's-complement negation
  // are the magnitude; the carry into the sign bit is intentionally dropped.
  always_comb begin
    mag_o = x_i[WIDTH-2:0];
    if (is_min)
      mag_o = '1;
    else if (x_i[WIDTH-1])
      mag_o = ~x_i[WIDTH-2:0] + (WIDTH-1)'(1);
  end

endmodule

// File: rtl/audio_magnitude_averager.sv
// Mean absolute magnitude of an audio stream over a 2^LOG2_WINDOW sample window,
// published with a ready/acknowledge handshake for a firmware reader.
//   clk, reset    clock and synchronous active-high reset
//   sample_valid  sample qualifier, may be high every cycle
//   sample        signed audio sample
//   rd_ack        one-cycle pulse: reader has consumed avg_data
//   avg_data      top OUT_WIDTH bits of the latest window mean magnitude
//   avg_ready     an unread result is present
//   overrun       sticky: a result was replaced before it was acknowledged
module audio_magnitude_averager
  import audio_avg_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int LOG2_WINDOW  = LOG2_WINDOW_DEF,
  parameter int OUT_WIDTH    = OUT_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  input  logic                    rd_ack,
  output logic [OUT_WIDTH-1:0]    avg_data,
  output logic                    avg_ready,
  output logic                    overrun
);

  localparam int MW = SAMPLE_WIDTH - 1;
  localparam int AW = acc_width(SAMPLE_WIDTH, LOG2_WINDOW);

  // Stage 1: registered magnitude
  logic [MW-1:0] abs_w, abs_q;
  logic          abs_vld_q;

  abs_saturate #(.WIDTH(SAMPLE_WIDTH)) u_abs (
    .x_i   (sample),
    .mag_o (abs_w)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      abs_q     <= '0;
      abs_vld_q <= 1'b0;
    end else begin
      abs_vld_q <= sample_valid;
      if (sample_valid) abs_q <= abs_w;
    end
  end

  // Stage 2: window accumulation
  logic [AW-1:0]          acc_q, acc_d, sum_w;
  logic [LOG2_WINDOW-1:0] cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]   avg_q, avg_d;
  logic                   publish;

  assign sum_w = acc_q + AW'(abs_q);

  // The mean is sum >> LOG2_WINDOW; its top OUT_WIDTH bits are simply the
  // top OUT_WIDTH bits of the sum, so no explicit shift is needed.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    avg_d   = avg_q;
    publish = 1'b0;
    if (abs_vld_q) begin
      cnt_d = cnt_q + LOG2_WINDOW'(1);
      if (&cnt_q) begin
        publish = 1'b1;
        acc_d   = '0;
        avg_d   = sum_w[AW-1 -: OUT_WIDTH];
      end else begin
        acc_d = sum_w;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      avg_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      avg_q <= avg_d;
    end
  end

  // Output handshake FSM
  state_e state_q, state_d;
  logic   ovr_q, ovr_d;

  always_comb begin
    state_d = state_q;
    ovr_d   = ovr_q;
    if (state_q == ST_EMPTY) begin
      if (publish) state_d = ST_FULL;
    end else begin
      if (publish) begin
        // A coincident ack consumed the old value, so it is not an overrun.
        if (!rd_ack) ovr_d = 1'b1;
      end else if (rd_ack) begin
        state_d = ST_EMPTY;
        ovr_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovr_q   <= ovr_d;
    end
  end

  assign avg_data  = avg_q;
  assign avg_ready = (state_q == ST_FULL);
  assign overrun   = ovr_q;

endmodule
